// File: rtl/video_capture_if.sv
// video_capture_if: groups the pixel stream, capture control, framebuffer write port and
// frame measurement results of video_capture.
//   master : stream/arm source and result consumer (testbench or SoC glue)
//   slave  : the capture block itself
// Signals: ce_pix, vga_hs/vs/de, vga_r/g/b (stream); arm, busy, done (control);
//          wr_en, wr_addr, wr_data (framebuffer write); frame_w, frame_h, overflow (results).
interface video_capture_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              ce_pix;
    logic              vga_hs;
    logic              vga_vs;
    logic              vga_de;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;
    logic              arm;
    logic              busy;
    logic              done;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [11:0]       frame_w;
    logic [11:0]       frame_h;
    logic              overflow;

    modport master (
        output ce_pix, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, arm,
        input  busy, done, wr_en, wr_addr, wr_data, frame_w, frame_h, overflow
    );

    modport slave (
        input  ce_pix, vga_hs, vga_vs, vga_de, vga_r, vga_g, vga_b, arm,
        output busy, done, wr_en, wr_addr, wr_data, frame_w, frame_h, overflow
    );
endinterface

// File: rtl/video_capture.sv
// video_capture: captures one complete frame of a VGA-style pixel stream into a framebuffer
// (RGB332, address y*MAX_W + x) on request, and measures the frame's active width/height.
// Ports:
//   clk_sys : pixel/system clock
//   reset   : synchronous, active-high
//   vif     : video_capture_if slave modport (stream in, arm/busy/done, write port, results)
module video_capture #(
    parameter int unsigned MAX_W  = 160,
    parameter int unsigned MAX_H  = 100,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    video_capture_if.slave        vif
);

    if (MAX_W * MAX_H > (1 << ADDR_W)) begin : g_size_check
        $error("video_capture: MAX_W*MAX_H does not fit in ADDR_W address bits");
    end

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitVs  = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    localparam logic [11:0]       MaxW12  = 12'(MAX_W);
    localparam logic [11:0]       MaxH12  = 12'(MAX_H);
    localparam logic [ADDR_W-1:0] RowStep = ADDR_W'(MAX_W);

    logic [1:0]        state_q, state_d;
    logic              vs_prev_q, vs_prev_d;
    logic              de_prev_q, de_prev_d;
    logic [11:0]       x_q, x_d;
    logic [11:0]       y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [11:0]       max_w_q, max_w_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic [11:0]       frame_w_q, frame_w_d;
    logic [11:0]       frame_h_q, frame_h_d;
    logic              overflow_q, overflow_d;

    logic              vs_rise, de_fall;
    logic [11:0]       line_w, height, widest;

    // Only bits that reach the framebuffer matter; hsync is not used for timing.
    logic unused_ok;
    assign unused_ok = ^{vif.vga_hs, vif.vga_r[4:0], vif.vga_g[4:0], vif.vga_b[5:0]};

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    assign vs_rise = vif.ce_pix &  vif.vga_vs & ~vs_prev_q;
    assign de_fall = vif.ce_pix & ~vif.vga_de &  de_prev_q;

    always_comb begin
        state_d    = state_q;
        vs_prev_d  = vs_prev_q;
        de_prev_d  = de_prev_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        max_w_d    = max_w_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        frame_w_d  = frame_w_q;
        frame_h_d  = frame_h_q;
        overflow_d = overflow_q;
        line_w     = 12'd0;
        height     = 12'd0;
        widest     = 12'd0;

        // Edge history advances only on qualified samples.
        if (vif.ce_pix) begin
            vs_prev_d = vif.vga_vs;
            de_prev_d = vif.vga_de;
        end

        case (state_q)
            StIdle: begin
                if (vif.arm) state_d = StWaitVs;
            end
            StWaitVs: begin
                if (vs_rise) begin
                    state_d    = StCapture;
                    x_d        = 12'd0;
                    y_d        = 12'd0;
                    row_base_d = '0;
                    max_w_d    = 12'd0;
                end
            end
            StCapture: begin
                if (vs_rise) begin
                    // A line still open at vsync counts toward the frame size.
                    line_w     = de_prev_q ? x_q : 12'd0;
                    height     = de_prev_q ? sat_inc(y_q) : y_q;
                    widest     = (line_w > max_w_q) ? line_w : max_w_q;
                    state_d    = StIdle;
                    done_d     = 1'b1;
                    frame_w_d  = widest;
                    frame_h_d  = height;
                    overflow_d = (widest > MaxW12) || (height > MaxH12);
                end else if (vif.ce_pix && vif.vga_de) begin
                    if (x_q < MaxW12 && y_q < MaxH12) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = row_base_q + ADDR_W'(x_q);
                        wr_data_d = {vif.vga_r[7:5], vif.vga_g[7:5], vif.vga_b[7:6]};
                    end
                    x_d = sat_inc(x_q);
                end else if (de_fall) begin
                    if (x_q > max_w_q) max_w_d = x_q;
                    if (y_q < MaxH12) row_base_d = row_base_q + RowStep;
                    y_d = sat_inc(y_q);
                    x_d = 12'd0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= StIdle;
            vs_prev_q  <= 1'b0;
            de_prev_q  <= 1'b0;
            x_q        <= 12'd0;
            y_q        <= 12'd0;
            row_base_q <= '0;
            max_w_q    <= 12'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            done_q     <= 1'b0;
            frame_w_q  <= 12'd0;
            frame_h_q  <= 12'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_prev_q  <= vs_prev_d;
            de_prev_q  <= de_prev_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            max_w_q    <= max_w_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            frame_w_q  <= frame_w_d;
            frame_h_q  <= frame_h_d;
            overflow_q <= overflow_d;
        end
    end

    assign vif.busy     = (state_q != StIdle);
    assign vif.done     = done_q;
    assign vif.wr_en    = wr_en_q;
    assign vif.wr_addr  = wr_addr_q;
    assign vif.wr_data  = wr_data_q;
    assign vif.frame_w  = frame_w_q;
    assign vif.frame_h  = frame_h_q;
    assign vif.overflow = overflow_q;

endmodule

// File: tb/tb_video_capture.sv
// tb_video_capture: directed frame sequences with random pixel colours; expected writes,
// done pulses and frame results come from a frame-level model (loop indices, y*160+x).
module tb_video_capture;

    localparam int MW = 160;
    localparam int MH = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    video_capture_if #(.ADDR_W(14)) vif ();

    video_capture #(.MAX_W(160), .MAX_H(100), .ADDR_W(14)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .vif     (vif)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    bit mon_on   = 1'b0;
    int ce_div   = 1;

    // Frame-level model state
    bit          m_busy = 1'b0;
    logic [11:0] m_fw   = 12'd0;
    logic [11:0] m_fh   = 12'd0;
    logic        m_ov   = 1'b0;

    // Expectation for the sample currently on the inputs, and its registered copy.
    logic        exp_wr = 1'b0, exp_wr_d = 1'b0;
    logic        exp_done = 1'b0, exp_done_d = 1'b0;
    logic [13:0] exp_addr = '0, exp_addr_d = '0;
    logic [7:0]  exp_data = '0, exp_data_d = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_wr_d   <= exp_wr;
        exp_done_d <= exp_done;
        exp_addr_d <= exp_addr;
        exp_data_d <= exp_data;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("wr_en", 32'(vif.wr_en), 32'(exp_wr_d));
            if (exp_wr_d) begin
                check("wr_addr", 32'(vif.wr_addr), 32'(exp_addr_d));
                check("wr_data", 32'(vif.wr_data), 32'(exp_data_d));
            end
            check("done", 32'(vif.done), 32'(exp_done_d));
            if (vif.wr_en === 1'b1) n_wr++;
        end
    end

    task automatic step(input bit ce, input bit vs, input bit de, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b, input bit a, input bit ew,
                        input logic [13:0] ea, input bit ed);
        @(posedge clk);
        #1;
        vif.ce_pix = ce;
        vif.vga_vs = vs;
        vif.vga_de = de;
        vif.vga_hs = ~de;
        vif.vga_r  = r;
        vif.vga_g  = g;
        vif.vga_b  = b;
        vif.arm    = a;
        exp_wr     = ew;
        exp_addr   = ea;
        exp_data   = {r[7:5], g[7:5], b[7:6]};
        exp_done   = ed;
    endtask

    // One qualified sample, preceded by ce_pix=0 cycles carrying junk.
    task automatic sample(input bit vs, input bit de, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input bit a, input bit ew, input logic [13:0] ea,
                          input bit ed);
        for (int i = 1; i < ce_div; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'b0, 1'b0, 14'd0, 1'b0);
        step(1'b1, vs, de, r, g, b, a, ew, ea, ed);
    endtask

    task automatic blank();
        sample(1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, 1'b0);
    endtask

    task automatic pix(input int x, input int y, input bit cap, input bit red, input bit a);
        logic [7:0] r, g, b;
        bit ew;
        r  = red ? 8'hE0 : 8'($urandom);
        g  = red ? 8'h00 : 8'($urandom);
        b  = red ? 8'h00 : 8'($urandom);
        ew = cap && (x < MW) && (y < MH);
        sample(1'b0, 1'b1, r, g, b, a, ew, 14'(y * MW + x), 1'b0);
    endtask

    task automatic do_arm();
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 14'd0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        m_busy = 1'b1;
        check("busy_after_arm", 32'(vif.busy), 32'd1);
    endtask

    // Full frame: vs rise, h lines of w pixels, closing vs rise.
    task automatic frame(input int w, input int h, input bit clash, input bit red,
                         input int arm_line);
        bit cap;
        int exp_wr_cnt, lw;
        cap  = m_busy;
        n_wr = 0;
        sample(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        blank();
        blank();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (clash && y == h - 1 && x == w - 1)
                    sample(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 14'd0, cap);
                else
                    pix(x, y, cap, red, (y == arm_line) && (x == 0));
            end
            if (!(clash && y == h - 1)) begin
                blank();
                blank();
            end
        end
        if (!clash) sample(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, cap);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        if (cap) begin
            lw     = (clash && h == 1) ? w - 1 : w;
            m_fw   = 12'(lw);
            m_fh   = 12'(h);
            m_ov   = (lw > MW) || (h > MH);
            m_busy = 1'b0;
        end
        exp_wr_cnt = cap ? ((h < MH ? h : MH) * (w < MW ? w : MW)) : 0;
        if (cap && clash && (h - 1) < MH && (w - 1) < MW) exp_wr_cnt--;
        check("busy_end", 32'(vif.busy), 32'(m_busy));
        check("frame_w", 32'(vif.frame_w), 32'(m_fw));
        check("frame_h", 32'(vif.frame_h), 32'(m_fh));
        check("overflow", 32'(vif.overflow), 32'(m_ov));
        blank();
        check("write_count", 32'(n_wr), 32'(exp_wr_cnt));
    endtask

    initial begin
        vif.ce_pix = 1'b0;
        vif.vga_hs = 1'b0;
        vif.vga_vs = 1'b0;
        vif.vga_de = 1'b0;
        vif.vga_r  = 8'd0;
        vif.vga_g  = 8'd0;
        vif.vga_b  = 8'd0;
        vif.arm    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(vif.busy), 32'd0);
        check("rst_done", 32'(vif.done), 32'd0);
        check("rst_wr_en", 32'(vif.wr_en), 32'd0);
        check("rst_wr_addr", 32'(vif.wr_addr), 32'd0);
        check("rst_wr_data", 32'(vif.wr_data), 32'd0);
        check("rst_frame_w", 32'(vif.frame_w), 32'd0);
        check("rst_frame_h", 32'(vif.frame_h), 32'd0);
        check("rst_overflow", 32'(vif.overflow), 32'd0);
        reset  = 1'b0;
        mon_on = 1'b1;

        // 8x4 red frame
        do_arm();
        frame(8, 4, 1'b0, 1'b1, -1);

        // Oversize frame: only the 160x100 window is stored
        do_arm();
        frame(200, 120, 1'b0, 1'b0, -1);

        // Sparse pixel enable
        ce_div = 4;
        do_arm();
        frame(4, 2, 1'b0, 1'b0, -1);
        ce_div = 1;

        // Second arm while busy is ignored; a frame with no arm captures nothing
        do_arm();
        frame(6, 3, 1'b0, 1'b0, 1);
        frame(5, 2, 1'b0, 1'b0, -1);

        // Reset in the middle of a capture
        do_arm();
        sample(1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 14'd0, 1'b0);
        blank();
        for (int x = 0; x < 8; x++) pix(x, 0, 1'b1, 1'b0, 1'b0);
        blank();
        for (int x = 0; x < 3; x++) pix(x, 1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        vif.ce_pix = 1'b0;
        vif.arm    = 1'b0;
        exp_wr     = 1'b0;
        exp_done   = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        m_busy = 1'b0;
        m_fw   = 12'd0;
        m_fh   = 12'd0;
        m_ov   = 1'b0;
        check("midrst_busy", 32'(vif.busy), 32'd0);
        check("midrst_wr_en", 32'(vif.wr_en), 32'd0);
        check("midrst_frame_w", 32'(vif.frame_w), 32'd0);
        check("midrst_frame_h", 32'(vif.frame_h), 32'd0);
        vif.vga_vs = 1'b0;
        vif.vga_de = 1'b0;
        do_arm();
        frame(8, 4, 1'b0, 1'b0, -1);

        // vs rise on the last pixel of the last line
        do_arm();
        frame(8, 4, 1'b1, 1'b0, -1);

        // Random small frames at random pixel rates
        repeat (3) begin
            ce_div = int'($urandom_range(1, 3));
            do_arm();
            frame(int'($urandom_range(2, 24)), int'($urandom_range(1, 8)),
                  1'($urandom), 1'b0, -1);
        end
        ce_div = 1;

        repeat (3) blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
